// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: byte-serial wide adder sequencer driving one external 8-bit
// adder slice, LS byte first, with valid/ready handshakes on both sides.
module adder_seq_ctrl #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WORDS-1:0]   in_a,
  input  logic [8*WORDS-1:0]   in_b,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORDS-1:0]   out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 busy,
  output logic [7:0]           slc_a,
  output logic [7:0]           slc_b,
  output logic                 slc_cin,
  input  logic [7:0]           slc_sum,
  input  logic                 slc_cout
);

  localparam int unsigned W      = 8 * WORDS;
  localparam int unsigned BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat;
  logic              carry;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic              ovf_c;

  // Slice operands are only driven while a beat is in flight.
  always_comb begin
    slc_a   = 8'h00;
    slc_b   = 8'h00;
    slc_cin = 1'b0;
    if (state == RUN) begin
      slc_a   = a_q[8*32'(beat) +: 8];
      slc_b   = b_q[8*32'(beat) +: 8];
      slc_cin = carry;
    end
  end

  // Signed overflow judged from the operand MSBs and the final slice result.
  always_comb begin
    ovf_c = (a_q[W-1] == b_q[W-1]) && (slc_sum[7] != a_q[W-1]);
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= in_b;
            carry    <= in_cin;
            beat     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          out_sum[8*32'(beat) +: 8] <= slc_sum;
          carry                     <= slc_cout;
          if (beat == LAST_BEAT) begin
            out_cout  <= slc_cout;
            out_ovf   <= ovf_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl: a 4-byte instance and a 1-byte instance,
// each wired to a behavioural 8-bit adder slice.
module tb_adder_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WORDS=4 instance
  logic        in_valid4 = 1'b0, in_ready4, in_cin4 = 1'b0;
  logic [31:0] in_a4 = '0, in_b4 = '0, out_sum4;
  logic        out_valid4, out_ready4 = 1'b0, out_cout4, out_ovf4, busy4;
  logic [7:0]  slc_a4, slc_b4, slc_sum4;
  logic        slc_cin4, slc_cout4;

  assign {slc_cout4, slc_sum4} = 9'({1'b0, slc_a4} + {1'b0, slc_b4} + 9'(slc_cin4));

  adder_seq_ctrl #(.WORDS(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_cout(out_cout4), .out_ovf(out_ovf4),
    .busy(busy4),
    .slc_a(slc_a4), .slc_b(slc_b4), .slc_cin(slc_cin4),
    .slc_sum(slc_sum4), .slc_cout(slc_cout4)
  );

  // WORDS=1 instance
  logic        in_valid1 = 1'b0, in_ready1, in_cin1 = 1'b0;
  logic [7:0]  in_a1 = '0, in_b1 = '0, out_sum1;
  logic        out_valid1, out_ready1 = 1'b0, out_cout1, out_ovf1, busy1;
  logic [7:0]  slc_a1, slc_b1, slc_sum1;
  logic        slc_cin1, slc_cout1;

  assign {slc_cout1, slc_sum1} = 9'({1'b0, slc_a1} + {1'b0, slc_b1} + 9'(slc_cin1));

  adder_seq_ctrl #(.WORDS(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1),
    .busy(busy1),
    .slc_a(slc_a1), .slc_b(slc_b1), .slc_cin(slc_cin1),
    .slc_sum(slc_sum1), .slc_cout(slc_cout1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation, step through the four beats checking the slice
  // drive, then check the result. exp_cin[i] is the carry into beat i.
  task automatic run_op4(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [3:0] exp_cin,
                         input logic [31:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf, input bit release_now);
    logic [31:0] av;
    logic [31:0] bv;
    av = a;
    bv = b;
    in_a4 = a; in_b4 = b; in_cin4 = cin; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq({tag, "_slc_a"},   64'(slc_a4),   64'(av[8*i +: 8]));
      check_eq({tag, "_slc_b"},   64'(slc_b4),   64'(bv[8*i +: 8]));
      check_eq({tag, "_slc_cin"}, 64'(slc_cin4), 64'(exp_cin[i]));
      check_eq({tag, "_valid_early"}, 64'(out_valid4), 64'(0));
      tick();
    end
    check_eq({tag, "_valid"}, 64'(out_valid4), 64'(1));
    check_eq({tag, "_sum"},   64'(out_sum4),   64'(exp_sum));
    check_eq({tag, "_cout"},  64'(out_cout4),  64'(exp_cout));
    check_eq({tag, "_ovf"},   64'(out_ovf4),   64'(exp_ovf));
    check_eq({tag, "_busy"},  64'(busy4),      64'(1));
    check_eq({tag, "_ready"}, 64'(in_ready4),  64'(0));
    check_eq({tag, "_slc_a_done"}, 64'(slc_a4), 64'(0));
    if (release_now) begin
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
      check_eq({tag, "_valid_clr"}, 64'(out_valid4), 64'(0));
      check_eq({tag, "_ready_ret"}, 64'(in_ready4),  64'(1));
      check_eq({tag, "_busy_clr"},  64'(busy4),      64'(0));
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid",   64'(out_valid4), 64'(0));
    check_eq("rst_busy",    64'(busy4),      64'(0));
    check_eq("rst_ready",   64'(in_ready4),  64'(1));
    check_eq("rst_sum",     64'(out_sum4),   64'(0));
    rst = 1'b0;
    tick();
    check_eq("post_rst_ready", 64'(in_ready4), 64'(1));

    // Test 1: reset during the second RUN beat
    in_a4 = 32'h11223344; in_b4 = 32'h01010101; in_cin4 = 1'b0; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick();
    check_eq("t1_slc_a_beat1", 64'(slc_a4), 64'h33);
    check_eq("t1_busy_run",    64'(busy4),  64'(1));
    #2 rst = 1'b1;
    #1;
    check_eq("t1_valid",   64'(out_valid4), 64'(0));
    check_eq("t1_busy",    64'(busy4),      64'(0));
    check_eq("t1_slc_a",   64'(slc_a4),     64'(0));
    check_eq("t1_slc_b",   64'(slc_b4),     64'(0));
    check_eq("t1_slc_cin", 64'(slc_cin4),   64'(0));
    rst = 1'b0;
    tick();
    check_eq("t1_ready", 64'(in_ready4), 64'(1));
    check_eq("t1_sum",   64'(out_sum4),  64'(0));

    // Test 2: single carry between beats 0 and 1
    run_op4("t2", 32'h000000FF, 32'h00000001, 1'b0, 4'b0010,
            32'h00000100, 1'b0, 1'b0, 1'b1);
    // Test 3: carry ripples through every beat
    run_op4("t3", 32'hFFFFFFFF, 32'h00000000, 1'b1, 4'b1111,
            32'h00000000, 1'b1, 1'b0, 1'b1);
    // Test 4: positive and negative overflow
    run_op4("t4a", 32'h7FFFFFFF, 32'h00000001, 1'b0, 4'b1110,
            32'h80000000, 1'b0, 1'b1, 1'b1);
    run_op4("t4b", 32'h80000000, 32'h80000000, 1'b0, 4'b0000,
            32'h00000000, 1'b1, 1'b1, 1'b1);

    // Test 5: backpressure in DONE with in_valid toggling
    run_op4("t5", 32'h12345678, 32'h11111111, 1'b0, 4'b0000,
            32'h23456789, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid4 = (i % 2 == 0);
      in_a4 = 32'hDEAD0000 + 32'(i);
      in_b4 = 32'h0000BEEF;
      tick();
      check_eq("t5_hold_valid", 64'(out_valid4), 64'(1));
      check_eq("t5_hold_sum",   64'(out_sum4),   64'h23456789);
      check_eq("t5_hold_ready", 64'(in_ready4),  64'(0));
      check_eq("t5_hold_slc",   64'(slc_a4),     64'(0));
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check_eq("t5_ready",    64'(in_ready4),  64'(1));
    check_eq("t5_valid",    64'(out_valid4), 64'(0));
    check_eq("t5_busy",     64'(busy4),      64'(0));
    tick();
    check_eq("t5_no_accept", 64'(busy4), 64'(0));

    // Test 6: single-beat instance
    check_eq("t6_ready0", 64'(in_ready1), 64'(1));
    in_a1 = 8'hE0; in_b1 = 8'h06; in_cin1 = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check_eq("t6_slc_a",   64'(slc_a1),     64'hE0);
    check_eq("t6_slc_b",   64'(slc_b1),     64'h06);
    check_eq("t6_valid0",  64'(out_valid1), 64'(0));
    tick();
    check_eq("t6_valid",   64'(out_valid1), 64'(1));
    check_eq("t6_sum",     64'(out_sum1),   64'hE6);
    check_eq("t6_cout",    64'(out_cout1),  64'(0));
    check_eq("t6_ovf",     64'(out_ovf1),   64'(0));
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check_eq("t6_ready",   64'(in_ready1),  64'(1));
    check_eq("t6_valid_clr", 64'(out_valid1), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
